fifo_rd_ctrl: RTL and testbench



---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_ptr_sync.sv | 43 ++++
 rtl/fifo_rd_ctrl.sv | 119 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO pointer controllers. The read-side
// and write-side controllers both import this package.
//   FIFO_ADDRESS_WIDTH / FIFO_DEPTH : default memory geometry
//   ptr_t                          : widest pointer the helpers handle
//   bin2gray / gray2bin            : pointer code conversions
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_ADDRESS_WIDTH = 3;
  localparam int FIFO_DEPTH         = 2 ** FIFO_ADDRESS_WIDTH;

  // Helpers work on a wide vector so they serve any ADDRESS_WIDTH. Narrower
  // pointers are zero-extended by the caller; leading zeros pass through both
  // conversions unchanged, so truncating the result gives the exact answer.
  localparam int PTR_MAX_WIDTH = 16;
  typedef logic [PTR_MAX_WIDTH-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[PTR_MAX_WIDTH-1] = gray[PTR_MAX_WIDTH-1];
    for (int i = PTR_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// -----------------------------------------------------------------------------
// fifo_ptr_sync
// Multi-flop synchronizer for a Gray-coded FIFO pointer crossing into clk.
// Used for W_PTR on the read side and for R_PTR on the write side.
// Parameters: WIDTH (pointer bits), NUM_STAGES (flop stages, 2..4).
// Ports:
//   clk    destination-domain clock
//   rst_n  asynchronous active-low reset, clears every stage
//   d      pointer from the source domain
//   q      synchronized pointer (last stage)
// -----------------------------------------------------------------------------
module fifo_ptr_sync #(
  parameter int WIDTH      = 4,
  parameter int NUM_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [NUM_STAGES];

  // NOTE: this small flop array is reset element by element; it is a register
  // chain, not a RAM, so resetting it costs nothing and keeps flags sane.
  // NOTE: non-blocking assignments let every stage sample the previous stage's
  // old value, which is what makes this a shift chain rather than a wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < NUM_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[NUM_STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side pointer and flag controller of the async FIFO (R_CLK domain).
// Synchronizes the write Gray pointer, advances the read pointer on accepted
// reads, and produces registered EMPTY / ALMOST_EMPTY / R_LEVEL.
// Parameters: ADDRESS_WIDTH (depth = 2**ADDRESS_WIDTH), NUM_STAGES (2..4),
//             AE_LEVEL (ALMOST_EMPTY when level <= AE_LEVEL).
// Ports:
//   R_CLK         read clock
//   R_RST         asynchronous active-low reset
//   R_INC         read request (ignored while EMPTY)
//   W_PTR         write Gray pointer, asynchronous to R_CLK
//   R_ADDR        memory read address
//   R_PTR         registered read Gray pointer for the write side
//   EMPTY         registered empty flag
//   ALMOST_EMPTY  registered, level <= AE_LEVEL
//   R_LEVEL       registered occupancy 0..2**ADDRESS_WIDTH
//   UNDERFLOW     sticky underflow flag (only with FIFO_RD_UNDERFLOW_ERR_EN)
// Optional build macro: FIFO_RD_UNDERFLOW_ERR_EN adds the UNDERFLOW output.
// -----------------------------------------------------------------------------
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FIFO_ADDRESS_WIDTH,
  parameter int NUM_STAGES    = 2,
  parameter int AE_LEVEL      = 1
) (
  input  logic                     R_CLK,
  input  logic                     R_RST,
  input  logic                     R_INC,
  input  logic [ADDRESS_WIDTH:0]   W_PTR,
  output logic [ADDRESS_WIDTH-1:0] R_ADDR,
  output logic [ADDRESS_WIDTH:0]   R_PTR,
  output logic                     EMPTY,
  output logic                     ALMOST_EMPTY,
`ifdef FIFO_RD_UNDERFLOW_ERR_EN
  output logic [ADDRESS_WIDTH:0]   R_LEVEL,
  output logic                     UNDERFLOW
`else
  output logic [ADDRESS_WIDTH:0]   R_LEVEL
`endif
);

  localparam int PW = ADDRESS_WIDTH + 1;
  localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

  logic [PW-1:0] wq_ptr;
  logic [PW-1:0] r_bin;
  logic [PW-1:0] r_bin_next;
  logic [PW-1:0] r_gray_next;
  logic [PW-1:0] wq_bin;
  logic [PW-1:0] level_next;
  logic          empty_next;
  logic          ae_next;
  logic          rd_en;

  fifo_ptr_sync #(
    .WIDTH      (PW),
    .NUM_STAGES (NUM_STAGES)
  ) u_wptr_sync (
    .clk   (R_CLK),
    .rst_n (R_RST),
    .d     (W_PTR),
    .q     (wq_ptr)
  );

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    rd_en       = 1'b0;
    r_bin_next  = r_bin;
    r_gray_next = '0;
    wq_bin      = '0;
    level_next  = '0;
    empty_next  = 1'b1;
    ae_next     = 1'b1;

    rd_en       = R_INC & ~EMPTY;
    r_bin_next  = r_bin + PW'(rd_en);
    r_gray_next = PW'(bin2gray(ptr_t'(r_bin_next)));
    wq_bin      = PW'(gray2bin(ptr_t'(wq_ptr)));
    // Modular subtraction: the extra MSB makes a full FIFO read as DEPTH and
    // handles the write pointer being a lap ahead in binary.
    level_next  = wq_bin - r_bin_next;
    // Full-width Gray compare, MSB included, so full is never mistaken for empty.
    empty_next  = (r_gray_next == wq_ptr);
    ae_next     = (level_next <= AE_THRESH);
  end

  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      r_bin        <= '0;
      R_PTR        <= '0;
      EMPTY        <= 1'b1;
      ALMOST_EMPTY <= 1'b1;
      R_LEVEL      <= '0;
    end else begin
      r_bin        <= r_bin_next;
      R_PTR        <= r_gray_next;
      EMPTY        <= empty_next;
      ALMOST_EMPTY <= ae_next;
      R_LEVEL      <= level_next;
    end
  end

  assign R_ADDR = r_bin[ADDRESS_WIDTH-1:0];

`ifdef FIFO_RD_UNDERFLOW_ERR_EN
  // Sticky until reset so firmware can poll it after the fact.
  always_ff @(posedge R_CLK or negedge R_RST) begin
    if (!R_RST) begin
      UNDERFLOW <= 1'b0;
    end else if (R_INC && EMPTY) begin
      UNDERFLOW <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
// Directed self-checking bench for fifo_rd_ctrl with default parameters
// (ADDRESS_WIDTH=3, NUM_STAGES=2, AE_LEVEL=1). Define FIFO_RD_UNDERFLOW_ERR_EN
// to also exercise the UNDERFLOW output.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

  logic       R_CLK = 1'b0;
  logic       R_RST = 1'b0;
  logic       R_INC = 1'b0;
  logic [3:0] W_PTR = '0;
  logic [2:0] R_ADDR;
  logic [3:0] R_PTR;
  logic       EMPTY;
  logic       ALMOST_EMPTY;
  logic [3:0] R_LEVEL;
`ifdef FIFO_RD_UNDERFLOW_ERR_EN
  logic       UNDERFLOW;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fifo_rd_ctrl #(
    .ADDRESS_WIDTH (3),
    .NUM_STAGES    (2),
    .AE_LEVEL      (1)
  ) dut (
    .R_CLK        (R_CLK),
    .R_RST        (R_RST),
    .R_INC        (R_INC),
    .W_PTR        (W_PTR),
    .R_ADDR       (R_ADDR),
    .R_PTR        (R_PTR),
    .EMPTY        (EMPTY),
    .ALMOST_EMPTY (ALMOST_EMPTY),
`ifdef FIFO_RD_UNDERFLOW_ERR_EN
    .R_LEVEL      (R_LEVEL),
    .UNDERFLOW    (UNDERFLOW)
`else
    .R_LEVEL      (R_LEVEL)
`endif
  );

  always #5 R_CLK = ~R_CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge R_CLK);
    #1;
  endtask

  function automatic logic [3:0] gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_empty"}, 32'(EMPTY), 1);
    check({tag, "_ae"},    32'(ALMOST_EMPTY), 1);
    check({tag, "_level"}, 32'(R_LEVEL), 0);
    check({tag, "_addr"},  32'(R_ADDR), 0);
    check({tag, "_ptr"},   32'(R_PTR), 0);
  endtask

  initial begin
    int rb;
    int wb;

    // 1. Reset and idle.
    #12;
    R_RST = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check_reset_vals("idle");

    // 2. One write becomes visible on the third edge.
    W_PTR = gray(1);
    tick();
    check("lat_e1_empty", 32'(EMPTY), 1);
    tick();
    check("lat_e2_empty", 32'(EMPTY), 1);
    tick();
    check("lat_e3_empty", 32'(EMPTY), 0);
    check("lat_e3_level", 32'(R_LEVEL), 1);
    check("lat_e3_ae",    32'(ALMOST_EMPTY), 1);

    // 3. Full FIFO, then drain with R_INC held for 10 cycles.
    W_PTR = gray(8);
    for (int i = 0; i < 3; i++) tick();
    check("full_level", 32'(R_LEVEL), 8);
    check("full_empty", 32'(EMPTY), 0);
    check("full_ae",    32'(ALMOST_EMPTY), 0);
    check("full_addr",  32'(R_ADDR), 0);
    R_INC = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      rb = (k > 8) ? 8 : k;
      tick();
      check($sformatf("drain%0d_addr", k),  32'(R_ADDR), 32'(rb % 8));
      check($sformatf("drain%0d_level", k), 32'(R_LEVEL), 32'(8 - rb));
      check($sformatf("drain%0d_empty", k), 32'(EMPTY), (rb == 8) ? 1 : 0);
      check($sformatf("drain%0d_ae", k),    32'(ALMOST_EMPTY), (8 - rb <= 1) ? 1 : 0);
      check($sformatf("drain%0d_ptr", k),   32'(R_PTR), 32'(gray(rb)));
    end
    R_INC = 1'b0;
    check("drain_ptr_final", 32'(R_PTR), 32'h0000_000c);

    // 4. Write one / read one until the read pointer wraps back to 0.
    rb = 8;
    wb = 8;
    for (int i = 0; i < 8; i++) begin
      wb = (wb + 1) % 16;
      W_PTR = gray(wb);
      tick();
      check($sformatf("wrap%0d_early1", i), 32'(EMPTY), 1);
      tick();
      check($sformatf("wrap%0d_early2", i), 32'(EMPTY), 1);
      tick();
      check($sformatf("wrap%0d_vis", i),   32'(EMPTY), 0);
      check($sformatf("wrap%0d_lvl", i),   32'(R_LEVEL), 1);
      R_INC = 1'b1;
      tick();
      R_INC = 1'b0;
      rb = (rb + 1) % 16;
      check($sformatf("wrap%0d_empty", i), 32'(EMPTY), 1);
      check($sformatf("wrap%0d_ptr", i),   32'(R_PTR), 32'(gray(rb)));
    end
    check("wrap_ptr_zero",  32'(R_PTR), 0);
    check("wrap_addr_zero", 32'(R_ADDR), 0);

    // 5. Level 3, read one, then asynchronous reset between edges.
    W_PTR = gray(3);
    for (int i = 0; i < 3; i++) tick();
    check("l3_level", 32'(R_LEVEL), 3);
    check("l3_ae",    32'(ALMOST_EMPTY), 0);
    R_INC = 1'b1;
    tick();
    R_INC = 1'b0;
    check("l2_level", 32'(R_LEVEL), 2);
    check("l2_addr",  32'(R_ADDR), 1);
    check("l2_ptr",   32'(R_PTR), 32'(gray(1)));
    @(negedge R_CLK);
    R_RST = 1'b0;
    W_PTR = '0;
    #1;
    check_reset_vals("arst");
    @(negedge R_CLK);
    R_RST = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_reset_vals("post_rst");

`ifdef FIFO_RD_UNDERFLOW_ERR_EN
    // 6. Sticky underflow.
    check("uf_reset", 32'(UNDERFLOW), 0);
    R_INC = 1'b1;
    tick();
    R_INC = 1'b0;
    check("uf_set",  32'(UNDERFLOW), 1);
    check("uf_addr", 32'(R_ADDR), 0);
    W_PTR = gray(1);
    for (int i = 0; i < 3; i++) tick();
    R_INC = 1'b1;
    tick();
    R_INC = 1'b0;
    check("uf_valid_rd_addr", 32'(R_ADDR), 1);
    check("uf_sticky", 32'(UNDERFLOW), 1);
    @(negedge R_CLK);
    R_RST = 1'b0;
    W_PTR = '0;
    #1;
    check("uf_cleared", 32'(UNDERFLOW), 0);
    @(negedge R_CLK);
    R_RST = 1'b1;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
